// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared state encoding and default data width for the memory
//               access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  // Default machine word width of the multi-cycle CPU family
  localparam int WORD_SIZE_DEF = 16;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_counter
// Description : Loadable up/down counter with a terminal-count compare flag.
//               Counts down for fixed latency, up for timeout supervision.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             step,
  input  logic             count_up,
  input  logic [WIDTH-1:0] term_value,
  output logic [WIDTH-1:0] count,
  output logic             term_hit
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load has priority over stepping
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (step) begin
      count_d = count_up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign term_hit = (count_q == term_value);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Request/response memory-port sequencer. Drives readM/writeM,
//               the address and the shared tristate data bus; completes on a
//               fixed latency or on mem_ready with optional timeout; counts
//               completed reads and writes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int ADDR_W    = 16,
  parameter int LATENCY   = 2,
  parameter int HANDSHAKE = 0,
  parameter int TIMEOUT   = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [ADDR_W-1:0]    address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 mem_ready,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count
);

  // Counter must hold LATENCY-1 (count-down) and TIMEOUT-1 (count-up)
  localparam int WAIT_MAX = (LATENCY > TIMEOUT) ? LATENCY : TIMEOUT;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] LOAD_VAL =
      (HANDSHAKE != 0) ? '0 : WAIT_W'(LATENCY - 1);
  localparam logic [WAIT_W-1:0] TERM_VAL =
      (HANDSHAKE != 0) ? WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0) : '0;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]     rd_count_q, rd_count_d;
  logic [CNT_W-1:0]     wr_count_q, wr_count_d;
  logic                 err_q, err_d;

  logic                 cnt_load;
  logic                 cnt_step;
  logic                 term_hit;
  logic [WAIT_W-1:0]    wait_count;
  logic                 timed_out;
  logic                 done;

  mem_wait_counter #(
    .WIDTH (WAIT_W)
  ) u_wait (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (cnt_load),
    .load_value (LOAD_VAL),
    .step       (cnt_step),
    .count_up   (HANDSHAKE != 0),
    .term_value (TERM_VAL),
    .count      (wait_count),
    .term_hit   (term_hit)
  );

  // Completion decode for the current strobe cycle
  always_comb begin
    timed_out = (HANDSHAKE != 0) && (TIMEOUT > 0) && term_hit && !mem_ready;
    done      = (HANDSHAKE != 0) ? (mem_ready || timed_out) : term_hit;
  end

  // Next-state, request latching, completion bookkeeping
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    err_d      = err_q;
    cnt_load   = 1'b0;
    cnt_step   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = 1'b0;
          cnt_load = 1'b1;
          state_d  = req_write ? ST_WR : ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD, ST_WR: begin
        if (done) begin
          state_d = ST_RESP;
          err_d   = timed_out;
          if (!timed_out) begin
            if (state_q == ST_RD) begin
              rdata_d    = data;
              rd_count_d = rd_count_q + CNT_W'(1);
            end else begin
              wr_count_d = wr_count_q + CNT_W'(1);
            end
          end
        end else begin
          cnt_step = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end

  // Moore outputs; bus is driven only while in WR so it releases with writeM
  assign req_ready  = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = (state_q == ST_RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign readM      = (state_q == ST_RD);
  assign writeM     = (state_q == ST_WR);
  assign address    = addr_q;
  assign data       = (state_q == ST_WR) ? wdata_q : 'z;
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised memory-port sequencer for the multi-cycle CPU family.
- Replaces the core's direct single-cycle readM/writeM driving with a request/response handshake toward the core.
- Drives the shared tristate data bus, supports fixed-latency or memory-ready completion, optional timeout, and keeps read/write access counters.
- Sits between the micro-coded control/datapath and the external memory model.

Parameters:
WORD_SIZE, 16, data width (matches `WORD_SIZE)
ADDR_W, 16, address width
LATENCY, 2, fixed memory access cycles when HANDSHAKE=0; legal range >=1
HANDSHAKE, 0, 0 = complete after LATENCY cycles; 1 = complete on mem_ready
TIMEOUT, 0, HANDSHAKE=1 only: max wait cycles before error; 0 disables
CNT_W, 16, width of access counters

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  reset, asynchronous, active-low
req_valid  in  1  core requests an access
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  access address
req_wdata  in  WORD_SIZE  write data
req_ready  out  1  unit can accept a request this cycle
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  qualifies resp_valid: access timed out
resp_rdata  out  WORD_SIZE  last read data, held until the next read completes
readM  out  1  memory read strobe
writeM  out  1  memory write strobe
address  out  ADDR_W  memory address
data  inout  WORD_SIZE  shared memory data bus
mem_ready  in  1  memory completion, used only when HANDSHAKE=1
rd_count  out  CNT_W  completed reads, wraps modulo 2^CNT_W
wr_count  out  CNT_W  completed writes, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, active-low):
  - state = IDLE.
  - readM = writeM = 0; data bus = Z.
  - address, resp_rdata, rd_count, wr_count = 0.
  - resp_valid = resp_err = 0.
- States: IDLE, RD, WR, RESP. Outputs are Moore-decoded from registered state and latch registers; no combinational path from req_* to memory pins.
- req_ready = 1 in IDLE and RESP, 0 in RD and WR.
- Accepting a request (req_valid && req_ready at edge T):
  - latch req_addr, req_wdata and req_write.
  - wait counter = LATENCY-1 (HANDSHAKE=0) or 0 (HANDSHAKE=1).
  - next state is RD or WR.
- req_valid while req_ready=0 is ignored; the core must hold the request, the unit does not buffer it.
- RD: readM=1, address=latched addr, data=Z.
- WR: writeM=1, address=latched addr, data driven with latched wdata.
- Completion condition in RD/WR:
  - HANDSHAKE=0: counter==0; the counter otherwise decrements each cycle.
  - HANDSHAKE=1: mem_ready=1; the counter increments each cycle.
- Timeout (HANDSHAKE=1, TIMEOUT>0): if the counter reaches TIMEOUT-1 without mem_ready, complete with error.
- At completion:
  - RD: capture data into resp_rdata and increment rd_count (not on error).
  - WR: increment wr_count (not on error).
  - Go to RESP.
- RESP: resp_valid=1 for exactly one cycle; resp_err=1 if timed out.
  - A request presented in RESP is accepted (back-to-back); otherwise go to IDLE.
- Latency (HANDSHAKE=0): request at edge T; strobe high for cycles T+1..T+LATENCY; resp_valid at cycle T+LATENCY+1. Sustained throughput is one access per LATENCY+1 cycles.
- The bus is driven only in WR, so readM and data drive are never concurrent. Leaving WR releases the bus on the same edge the strobe drops.
- mem_ready outside RD/WR is ignored.
- HANDSHAKE=1 with mem_ready already high on the first RD/WR cycle completes after 1 cycle.
- Error responses leave resp_rdata unchanged.
- Reset asserted mid-access: strobes drop and the bus releases immediately (asynchronously); no resp_valid; counters clear.

Decomposition:
- Shared macro/package: state encoding (IDLE/RD/WR/RESP) and `WORD_SIZE. No other new constants.
- One natural sub-module, mem_wait_counter: loadable up/down counter with a terminal-count flag, parametrised on width. It serves both the fixed-latency and timeout modes.

Test Plan:
- LATENCY=2, HANDSHAKE=0: read addr 0x0010, memory returns 0xBEEF -> readM high exactly 2 cycles; resp_valid 3 cycles after accept; resp_rdata=0xBEEF; rd_count=1.
- LATENCY=2: write 0x1234 to 0x0020, then immediately read 0x0020 presented during RESP -> data driven only during WR; no idle gap; read returns 0x1234; wr_count=1, rd_count=1.
- HANDSHAKE=1, TIMEOUT=0: mem_ready asserted 5 cycles into a read -> readM high 5 cycles; resp_valid the following cycle; resp_err=0.
- HANDSHAKE=1, TIMEOUT=4: mem_ready never asserted -> after 4 strobe cycles resp_valid=1 and resp_err=1; rd_count unchanged; resp_rdata unchanged.
- req_valid toggled during RD -> ignored; req_ready=0; only one access is counted.
- reset_n pulled low in the middle of a WR cycle (between clock edges) -> writeM=0 and data=Z before the next edge; all counters 0; state IDLE with req_ready=1 after release.
